// File: rtl/ibuf_multiport_pkg.sv
// Shared defaults and small helpers for the multi-lane fetch-to-decode buffer.
// Optional same-cycle bypass is enabled by defining IBUF_BYPASS_EN.
package ibuf_multiport_pkg;

    localparam int SLOT_DEF  = 2;
    localparam int ISSUE_DEF = 2;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 64;
    localparam int DW_DEF    = 32;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ibuf_mport_ram.sv
// Entry storage: DEPTH x (PC,instr) registers, WP write ports, RP async reads.
// Contents are don't-care after reset, so the array has no reset.
module ibuf_mport_ram #(
    parameter int DEPTH = 8,
    parameter int EW    = 96,
    parameter int WP    = 2,
    parameter int RP    = 2,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic [WP-1:0]    we,
    input  logic [WP*IW-1:0] waddr,
    input  logic [WP*EW-1:0] wdata,
    input  logic [RP*IW-1:0] raddr,
    output logic [RP*EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Write addresses within one packet are always distinct.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < WP; k++) begin
            if (we[k]) begin
                mem[waddr[k*IW +: IW]] <= wdata[k*EW +: EW];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < RP; j++) begin
            rdata[j*EW +: EW] = mem[raddr[j*IW +: IW]];
        end
    end

endmodule

// File: rtl/ibuf_multiport.sv
// Multi-lane instruction buffer between ifetch and decode.
// Define IBUF_BYPASS_EN to forward packets into an empty buffer same-cycle.
module ibuf_multiport
    import ibuf_multiport_pkg::*;
#(
    parameter int SLOT  = SLOT_DEF,
    parameter int ISSUE = ISSUE_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [AW-1:0]                if_pc,
    input  logic [SLOT*DW-1:0]           if_instr,
    input  logic [SLOT-1:0]              if_mask,
    output logic [ISSUE-1:0]             id_valid,
    output logic [ISSUE*AW-1:0]          id_pc,
    output logic [ISSUE*DW-1:0]          id_instr,
    input  logic [$clog2(ISSUE+1)-1:0]   id_pop,
    output logic [$clog2(DEPTH+1)-1:0]   ibuf_cnt,
    output logic                         pop_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int EW = AW + DW;

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [SLOT-1:0]     we;
    logic [SLOT*IW-1:0]  waddr;
    logic [SLOT*EW-1:0]  wdata;
    logic [ISSUE*IW-1:0] raddr;
    logic [ISSUE*EW-1:0] rdata;
    logic                bypass;
    int                  mask_n;
    int                  push_n;
    int                  vis_n;
    int                  pop_n;
    int                  skip_n;

    // Extra pointer bit lets the difference reach DEPTH when full.
    assign ibuf_cnt = wr_ptr - rd_ptr;
    assign if_ready = (DEPTH - int'(ibuf_cnt)) >= SLOT;

`ifdef IBUF_BYPASS_EN
    localparam int ML = max_int(SLOT, ISSUE);
    logic [ML*DW-1:0] lanes;
    assign lanes  = (ML*DW)'(if_instr);
    assign bypass = (ibuf_cnt == '0) && if_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        mask_n = 0;
        for (int k = 0; k < SLOT; k++) begin
            if (if_mask[k]) mask_n = mask_n + 1;
        end
        push_n = (if_valid && if_ready && !flush) ? mask_n : 0;
        vis_n  = bypass ? min_int(mask_n, ISSUE)
                        : min_int(int'(ibuf_cnt), ISSUE);
        pop_n  = min_int(int'(id_pop), vis_n);
        // Bypassed lanes consumed this cycle never enter the array.
        skip_n = bypass ? pop_n : 0;
    end

    always_comb begin
        we    = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        for (int k = 0; k < SLOT; k++) begin
            we[k] = (push_n > 0) && if_mask[k] && (k >= skip_n);
            waddr[k*IW +: IW] = IW'(int'(wr_ptr[IW-1:0]) + k - skip_n);
            wdata[k*EW +: EW] = {if_pc + AW'(4 * k),
                                 if_instr[k*DW +: DW]};
        end
        for (int j = 0; j < ISSUE; j++) begin
            raddr[j*IW +: IW] = IW'(int'(rd_ptr[IW-1:0]) + j);
        end
    end

    always_comb begin
        id_valid = '0;
        id_pc    = '0;
        id_instr = '0;
        for (int j = 0; j < ISSUE; j++) begin
            id_valid[j] = j < vis_n;
            {id_pc[j*AW +: AW], id_instr[j*DW +: DW]} = rdata[j*EW +: EW];
`ifdef IBUF_BYPASS_EN
            if (bypass) begin
                id_pc[j*AW +: AW]    = if_pc + AW'(4 * j);
                id_instr[j*DW +: DW] = lanes[j*DW +: DW];
            end
`endif
        end
    end

    ibuf_mport_ram #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .WP    (SLOT),
        .RP    (ISSUE),
        .IW    (IW)
    ) u_ram (
        .CLK   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pop_err <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pop_err <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr + PW'(pop_n - skip_n);
            wr_ptr  <= wr_ptr + PW'(push_n - skip_n);
            pop_err <= int'(id_pop) > vis_n;
        end
    end

endmodule

// File: tb/tb_ibuf_multiport.sv
// Randomized bench for ibuf_multiport against a queue-based reference model.
module tb_ibuf_multiport;

    localparam int SLOT  = 2;
    localparam int ISSUE = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 64;
    localparam int DW    = 32;

    logic         CLK      = 1'b0;
    logic         RST      = 1'b0;
    logic         flush    = 1'b0;
    logic         if_valid = 1'b0;
    logic         if_ready;
    logic [63:0]  if_pc    = '0;
    logic [63:0]  if_instr = '0;
    logic [1:0]   if_mask  = '0;
    logic [1:0]   id_valid;
    logic [127:0] id_pc;
    logic [63:0]  id_instr;
    logic [1:0]   id_pop   = '0;
    logic [3:0]   ibuf_cnt;
    logic         pop_err;

    ibuf_multiport #(
        .SLOT  (SLOT),
        .ISSUE (ISSUE),
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_mask  (if_mask),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_pop   (id_pop),
        .ibuf_cnt (ibuf_cnt),
        .pop_err  (pop_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t q[$];
    bit   m_err;
    int   checks;
    int   errors;

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int pcnt(input logic [1:0] m);
        return int'(m[0]) + int'(m[1]);
    endfunction

    function automatic bit byp_now();
`ifdef IBUF_BYPASS_EN
        return (q.size() == 0) && if_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        int         sz = q.size();
        bit         b  = byp_now();
        int         n;
        logic [1:0] ev;
        logic [63:0] epc;
        logic [31:0] ein;
        chk("ibuf_cnt", 64'(ibuf_cnt), 64'(sz));
        chk("if_ready", 64'(if_ready), 64'((DEPTH - sz) >= SLOT));
        chk("pop_err", 64'(pop_err), 64'(m_err));
        n  = b ? mn(pcnt(if_mask), ISSUE) : mn(sz, ISSUE);
        ev = '0;
        for (int j = 0; j < ISSUE; j++) ev[j] = (j < n);
        chk("id_valid", 64'(id_valid), 64'(ev));
        for (int j = 0; j < n; j++) begin
            if (b) begin
                epc = if_pc + 64'(4 * j);
                ein = if_instr[j*32 +: 32];
            end else begin
                epc = q[j].pc;
                ein = q[j].ins;
            end
            chk("id_pc", id_pc[j*64 +: 64], epc);
            chk("id_instr", 64'(id_instr[j*32 +: 32]), 64'(ein));
        end
    endtask

    task automatic model_update();
        int sz = q.size();
        bit b  = byp_now();
        int vis;
        int pn;
        int pushn;
        if (flush) begin
            q.delete();
            m_err = 1'b0;
            return;
        end
        vis   = b ? mn(pcnt(if_mask), ISSUE) : mn(sz, ISSUE);
        pn    = mn(int'(id_pop), vis);
        m_err = int'(id_pop) > vis;
        pushn = (if_valid && (DEPTH - sz) >= SLOT) ? pcnt(if_mask) : 0;
        if (!b) repeat (pn) void'(q.pop_front());
        for (int k = 0; k < pushn; k++) begin
            if (!b || k >= pn)
                q.push_back({if_pc + 64'(4 * k), if_instr[k*32 +: 32]});
        end
    endtask

    task automatic step(input bit v, input logic [63:0] pc,
                        input logic [1:0] m, input logic [1:0] p,
                        input bit f);
        @(negedge CLK);
        if_valid = v;
        if_pc    = pc;
        if_instr = {$urandom, $urandom};
        if_mask  = m;
        id_pop   = p;
        flush    = f;
        #1 compare();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST      = 1'b1;
        if_valid = 1'b0;
        id_pop   = '0;
        flush    = 1'b0;
        #1;
        chk("rst_cnt", 64'(ibuf_cnt), 64'd0);
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_ready", 64'(if_ready), 64'd1);
        chk("rst_pop_err", 64'(pop_err), 64'd0);
        q.delete();
        m_err = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [63:0] pc;
        int          r;
        logic [1:0]  m;
        checks = 0;
        errors = 0;
        m_err  = 1'b0;
        #1;
        do_reset();

        step(1, 64'h8000_0000, 2'b11, 2'd0, 0);
        chk("basic_valid", 64'(id_valid), 64'h3);
        chk("basic_pc0", id_pc[63:0], 64'h8000_0000);
        chk("basic_pc1", id_pc[127:64], 64'h8000_0004);
        chk("basic_cnt", 64'(ibuf_cnt), 64'd2);
        step(0, 64'h0, 2'b00, 2'd2, 0);
        chk("basic_drain", 64'(ibuf_cnt), 64'd0);

        for (int i = 0; i < 4; i++)
            step(1, 64'h1000 + 64'(8 * i), 2'b11, 2'd0, 0);
        chk("full_cnt", 64'(ibuf_cnt), 64'd8);
        chk("full_ready", 64'(if_ready), 64'd0);
        step(1, 64'h2000, 2'b11, 2'd0, 0);
        chk("full_hold", 64'(ibuf_cnt), 64'd8);
        for (int i = 0; i < 4; i++) step(0, 64'h0, 2'b00, 2'd2, 0);

        step(1, 64'h4000, 2'b11, 2'd0, 0);
        for (int i = 0; i < 20; i++)
            step(1, 64'h4000 + 64'(8 * (i + 1)), 2'b11, 2'd2, 0);
        chk("wrap_cnt", 64'(ibuf_cnt), 64'd2);
        step(0, 64'h0, 2'b00, 2'd2, 0);

        for (int i = 0; i < 3; i++)
            step(1, 64'h5000 + 64'(8 * i), 2'b11, 2'd0, 0);
        step(1, 64'h5018, 2'b11, 2'd1, 0);
        chk("pushpop_cnt", 64'(ibuf_cnt), 64'd7);
        chk("pushpop_ready", 64'(if_ready), 64'd0);
        step(0, 64'h0, 2'b00, 2'd2, 0);
        chk("preflush_cnt", 64'(ibuf_cnt), 64'd5);
        step(1, 64'h6000, 2'b11, 2'd2, 1);
        chk("flush_cnt", 64'(ibuf_cnt), 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);

        step(1, 64'h7000, 2'b01, 2'd0, 0);
        step(0, 64'h0, 2'b00, 2'd2, 0);
        chk("overpop_cnt", 64'(ibuf_cnt), 64'd0);
        chk("overpop_err", 64'(pop_err), 64'd1);

        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b11, 2'd0, 0);
        chk("pcwrap_pc1", id_pc[127:64], 64'h0);

        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 2);
            m  = (r == 2) ? 2'b11 : 2'(r);
            pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            step($urandom_range(0, 3) != 0, pc, m,
                 2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
            if (i == 700) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
